wb_pia_arb: RTL and testbench

Two-master Wishbone arbiter for the single PIA slave port (RIOT I/O, timer and switch registers). It serialises accesses from master 0 (6502 CPU bus adapter) and master 1 (debug/OSD/loader port), and issues each access as exactly one slave strobe so that register side effects are never repeated. Selection is round-robin, and a timeout guards against a slave that never acknowledges.

---
 rtl/wb_pia_arb.sv | 184 ++++++++++++++++++
 tb/tb_wb_pia_arb.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pia_arb.sv
// Two-master Wishbone arbiter for the PIA slave port.
// Round-robin selection, one slave strobe per access, and a timeout if the slave never acks.
module wb_pia_arb #(
    parameter int unsigned TIMEOUT  = 15,
    parameter logic [7:0]  ERR_DATA = 8'hFF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       m0_stb_i,
    input  logic       m0_we_i,
    input  logic [6:0] m0_adr_i,
    input  logic [7:0] m0_dat_i,
    output logic       m0_ack_o,
    output logic       m0_err_o,
    output logic [7:0] m0_dat_o,
    input  logic       m1_stb_i,
    input  logic       m1_we_i,
    input  logic [6:0] m1_adr_i,
    input  logic [7:0] m1_dat_i,
    output logic       m1_ack_o,
    output logic       m1_err_o,
    output logic [7:0] m1_dat_o,
    output logic       s_stb_o,
    output logic       s_we_o,
    output logic [6:0] s_adr_o,
    output logic [7:0] s_dat_o,
    input  logic       s_ack_i,
    input  logic [7:0] s_dat_i,
    output logic [1:0] gnt_o
);

    localparam int unsigned ADR_W = 7;
    localparam int unsigned DAT_W = 8;
    localparam int unsigned CNT_W = 8;
    // A registered PIA can ack no earlier than one cycle after grant, so the window starts there.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               last_q, last_d;
    logic               owner_q, owner_d;
    logic               we_q, we_d;
    logic [ADR_W-1:0]   adr_q, adr_d;
    logic [DAT_W-1:0]   wdat_q, wdat_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         ack_q, ack_d;
    logic [1:0]         err_q, err_d;
    logic [DAT_W-1:0]   rdat0_q, rdat0_d;
    logic [DAT_W-1:0]   rdat1_q, rdat1_d;

    logic               grant_c;
    logic               sel_c;
    logic               ack_done_c;
    logic               to_done_c;
    logic [DAT_W-1:0]   cpl_dat_c;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and grant/completion decisions
    always_comb begin
        state_d    = state_q;
        grant_c    = 1'b0;
        sel_c      = 1'b0;
        ack_done_c = 1'b0;
        to_done_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (m0_stb_i || m1_stb_i) begin
                    grant_c = 1'b1;
                    sel_c   = (m0_stb_i && m1_stb_i) ? ~last_q : m1_stb_i;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (s_ack_i) begin
                    ack_done_c = 1'b1;
                    state_d    = ST_DONE;
                end else if (cnt_q == TO_LAST) begin
                    to_done_c = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Slave strobe drops combinationally with ack so the PIA sees exactly one strobe cycle
    always_comb begin
        s_stb_o = (state_q == ST_BUSY) && !s_ack_i;
        gnt_o   = 2'b00;
        if (state_q != ST_IDLE) begin
            gnt_o = owner_q ? 2'b10 : 2'b01;
        end
    end

    // Datapath next values: request latch, timeout counter, completion capture
    always_comb begin
        last_d    = last_q;
        owner_d   = owner_q;
        we_d      = we_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        cnt_d     = cnt_q;
        ack_d     = 2'b00;
        err_d     = 2'b00;
        rdat0_d   = rdat0_q;
        rdat1_d   = rdat1_q;
        cpl_dat_c = to_done_c ? ERR_DATA : s_dat_i;

        if (grant_c) begin
            last_d  = sel_c;
            owner_d = sel_c;
            we_d    = sel_c ? m1_we_i  : m0_we_i;
            adr_d   = sel_c ? m1_adr_i : m0_adr_i;
            wdat_d  = sel_c ? m1_dat_i : m0_dat_i;
            cnt_d   = '0;
        end

        if ((state_q == ST_BUSY) && !ack_done_c && !to_done_c && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (ack_done_c || to_done_c) begin
            ack_d[owner_q] = 1'b1;
            err_d[owner_q] = to_done_c;
            if (owner_q) begin
                rdat1_d = cpl_dat_c;
            end else begin
                rdat0_d = cpl_dat_c;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdat_q  <= '0;
            cnt_q   <= '0;
            ack_q   <= 2'b00;
            err_q   <= 2'b00;
            rdat0_q <= '0;
            rdat1_q <= '0;
        end else begin
            last_q  <= last_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdat0_q <= rdat0_d;
            rdat1_q <= rdat1_d;
        end
    end

    assign s_we_o   = we_q;
    assign s_adr_o  = adr_q;
    assign s_dat_o  = wdat_q;
    assign m0_ack_o = ack_q[0];
    assign m0_err_o = err_q[0];
    assign m0_dat_o = rdat0_q;
    assign m1_ack_o = ack_q[1];
    assign m1_err_o = err_q[1];
    assign m1_dat_o = rdat1_q;

endmodule

// File: tb/tb_wb_pia_arb.sv
// Bench for wb_pia_arb: PIA slave model, transaction-level reference schedule, directed and random traffic.
module tb_wb_pia_arb;

    localparam int unsigned TIMEOUT  = 15;
    localparam logic [7:0]  ERR_DATA = 8'hFF;

    logic       clk_i  = 1'b0;
    logic       rst_ni = 1'b0;
    logic       m0_stb_i, m0_we_i, m1_stb_i, m1_we_i;
    logic [6:0] m0_adr_i, m1_adr_i;
    logic [7:0] m0_dat_i, m1_dat_i;
    logic       m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [7:0] m0_dat_o, m1_dat_o;
    logic       s_stb_o, s_we_o;
    logic [6:0] s_adr_o;
    logic [7:0] s_dat_o;
    logic       s_ack_i = 1'b0;
    logic [7:0] s_dat_i = 8'h00;
    logic [1:0] gnt_o;

    wb_pia_arb #(.TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
        .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
        .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_ack_i(s_ack_i), .s_dat_i(s_dat_i), .gnt_o(gnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_err    = 0;

    // PIA model: registered ack one cycle after strobe, returns the old register value
    bit       pia_on    = 1'b1;
    bit       stray_ack = 1'b0;
    bit [7:0] pia_mem [128];
    bit       pia_wr  [128];

    function automatic logic [7:0] pia_init(input logic [6:0] a);
        return {1'b0, a} ^ 8'h38;
    endfunction

    always @(posedge clk_i) begin
        s_ack_i <= (s_stb_o && pia_on) || stray_ack;
        if (s_stb_o && pia_on) begin
            s_dat_i <= pia_wr[s_adr_o] ? pia_mem[s_adr_o] : pia_init(s_adr_o);
            if (s_we_o) begin
                pia_mem[s_adr_o] <= s_dat_o;
                pia_wr[s_adr_o]  <= 1'b1;
            end
        end
    end

    // Reference: one access at a time, scheduled by edge numbers
    int         cyc = 0;
    bit         act = 1'b0;
    int         g_edge = 0, a_cyc = 0, free_edge = 0;
    bit         own = 1'b0, last_m = 1'b1, to_flag = 1'b0;
    logic       e_we;
    logic [6:0] e_adr;
    logic [7:0] e_sdat;
    logic [7:0] e_rdat [2];
    logic [7:0] ref_mem [128];

    bit         req_v   [2];
    logic       req_we  [2];
    logic [6:0] req_adr [2];
    logic [7:0] req_dat [2];
    int         auto_n  [2];
    bit         rnd_mode = 1'b0;

    int         ack_seen [2];
    int         err_seen [2];
    int         stb_hi = 0;
    logic [1:0] gnt_prev = 2'b00;
    int         glog_own [$];
    int         glog_cyc [$];
    int         rq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive();
        m0_stb_i = req_v[0]; m0_we_i = req_we[0]; m0_adr_i = req_adr[0]; m0_dat_i = req_dat[0];
        m1_stb_i = req_v[1]; m1_we_i = req_we[1]; m1_adr_i = req_adr[1]; m1_dat_i = req_dat[1];
    endtask

    task automatic issue(input int x, input logic we, input logic [6:0] adr, input logic [7:0] dat);
        req_v[x] = 1'b1; req_we[x] = we; req_adr[x] = adr; req_dat[x] = dat;
        drive();
    endtask

    task automatic issue_rand(input int x);
        issue(x, 1'($urandom_range(1)), 7'($urandom_range(127)), 8'($urandom_range(255)));
    endtask

    task automatic model_reset();
        act = 1'b0; last_m = 1'b1; to_flag = 1'b0;
        e_we = 1'b0; e_adr = '0; e_sdat = '0; e_rdat[0] = '0; e_rdat[1] = '0;
        for (int x = 0; x < 2; x++) begin
            req_v[x] = 1'b0; req_we[x] = 1'b0; req_adr[x] = '0; req_dat[x] = '0; auto_n[x] = 0;
        end
        drive();
    endtask

    task automatic model_edge();
        if (!rst_ni) return;
        if (act && cyc > a_cyc) act = 1'b0;
        if (act && cyc == a_cyc) begin
            if (to_flag) begin
                e_rdat[own] = ERR_DATA;
            end else begin
                e_rdat[own] = ref_mem[e_adr];
                if (e_we) ref_mem[e_adr] = e_sdat;
            end
        end
        if (!act && cyc >= free_edge && (req_v[0] || req_v[1])) begin
            own       = (req_v[0] && req_v[1]) ? !last_m : req_v[1];
            last_m    = own;
            act       = 1'b1;
            g_edge    = cyc;
            to_flag   = !pia_on;
            a_cyc     = pia_on ? cyc + 2 : cyc + 1 + int'(TIMEOUT);
            free_edge = a_cyc + 2;
            e_we      = req_we[own];
            e_adr     = req_adr[own];
            e_sdat    = req_dat[own];
        end
    endtask

    task automatic check_cycle();
        bit         busy, done;
        logic [1:0] eg;
        busy = act && cyc >= g_edge && cyc < a_cyc;
        done = act && cyc == a_cyc;
        eg   = (busy || done) ? (own ? 2'b10 : 2'b01) : 2'b00;
        chk("gnt",    gnt_o,    eg);
        chk("s_stb",  s_stb_o,  busy && (to_flag || cyc == g_edge));
        chk("s_we",   s_we_o,   e_we);
        chk("s_adr",  s_adr_o,  e_adr);
        chk("s_dat",  s_dat_o,  e_sdat);
        chk("m0_ack", m0_ack_o, done && !own);
        chk("m0_err", m0_err_o, done && !own && to_flag);
        chk("m1_ack", m1_ack_o, done && own);
        chk("m1_err", m1_err_o, done && own && to_flag);
        chk("m0_dat", m0_dat_o, e_rdat[0]);
        chk("m1_dat", m1_dat_o, e_rdat[1]);
        if (s_stb_o)               stb_hi++;
        if (m0_ack_o)              ack_seen[0] = cyc;
        if (m1_ack_o)              ack_seen[1] = cyc;
        if (m0_ack_o && m0_err_o)  err_seen[0] = cyc;
        if (m1_ack_o && m1_err_o)  err_seen[1] = cyc;
        if (gnt_o != 2'b00 && gnt_prev == 2'b00) begin
            glog_own.push_back(int'(gnt_o));
            glog_cyc.push_back(cyc);
        end
        gnt_prev = gnt_o;
    endtask

    // Masters drop strobe after their ack and optionally re-request at once
    task automatic react();
        for (int x = 0; x < 2; x++) begin
            if (act && cyc == a_cyc && int'(own) == x) begin
                req_v[x] = 1'b0;
                if (auto_n[x] > 0) begin
                    auto_n[x]--;
                    issue_rand(x);
                end
            end
            if (rnd_mode && !req_v[x] && $urandom_range(2) == 0) issue_rand(x);
        end
        drive();
    endtask

    task automatic tick();
        @(posedge clk_i);
        cyc++;
        model_edge();
        @(negedge clk_i);
        check_cycle();
        react();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        for (int i = 0; i < 128; i++) ref_mem[i] = pia_init(7'(i));
        ack_seen[0] = -1; ack_seen[1] = -1; err_seen[0] = -1; err_seen[1] = -1;
        model_reset();
        rst_ni = 1'b0;
        run(3);
        rst_ni    = 1'b1;
        free_edge = cyc + 1;

        // Read by m1: PIA register 0x04 holds 0x3C
        rq = cyc + 1;
        issue(1, 1'b0, 7'h04, 8'h00);
        run(6);
        chk("rd_lat",  ack_seen[1] - rq, 2);
        chk("rd_hold", m1_dat_o, 8'h3C);

        // Single write by m0
        stb_hi = 0; ack_seen[1] = -1;
        rq = cyc + 1;
        issue(0, 1'b1, 7'h16, 8'h40);
        run(6);
        chk("wr_stb_cycles", stb_hi, 1);
        chk("wr_lat",        ack_seen[0] - rq, 2);
        chk("wr_no_m1_ack",  ack_seen[1], -1);

        // Reset in the middle of an access clears every output at once
        issue(0, 1'b0, 7'h10, 8'h00);
        tick();
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_stb",  s_stb_o, 0);
        chk("rst_gnt",  gnt_o, 0);
        chk("rst_adr",  s_adr_o, 0);
        chk("rst_m0d",  m0_dat_o, 0);
        chk("rst_m1d",  m1_dat_o, 0);
        chk("rst_acks", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 0);
        model_reset();
        run(2);
        rst_ni    = 1'b1;
        free_edge = cyc + 1;
        issue(0, 1'b0, 7'h20, 8'h00);
        issue(1, 1'b1, 7'h21, 8'h5A);
        tick();
        chk("rst_tie_gnt", gnt_o, 2'b01);
        run(10);

        // Continuous contention: 8 accesses must alternate, 4 cycles apart
        glog_own.delete(); glog_cyc.delete();
        auto_n[0] = 3; auto_n[1] = 3;
        issue_rand(0);
        issue_rand(1);
        run(40);
        chk("cont_count", glog_own.size(), 8);
        for (int i = 0; i < 8 && i < glog_own.size(); i++) begin
            chk("cont_owner", glog_own[i], (i % 2 == 0) ? 1 : 2);
            if (i > 0) chk("cont_gap", glog_cyc[i] - glog_cyc[i-1], 4);
        end

        // Silent slave: forced completion with error
        pia_on = 1'b0;
        ack_seen[0] = -1; err_seen[0] = -1;
        rq = cyc + 1;
        issue(0, 1'b0, 7'h05, 8'h00);
        run(20);
        chk("to_lat",  ack_seen[0] - rq, 16);
        chk("to_err",  err_seen[0] - rq, 16);
        chk("to_dat",  m0_dat_o, 8'hFF);
        pia_on = 1'b1;
        ack_seen[1] = -1;
        rq = cyc + 1;
        issue(1, 1'b0, 7'h04, 8'h00);
        run(6);
        chk("post_to_lat", ack_seen[1] - rq, 2);
        chk("post_to_dat", m1_dat_o, 8'h3C);

        // Stray ack while idle
        ack_seen[0] = -1; ack_seen[1] = -1;
        stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        run(3);
        chk("stray_m0", ack_seen[0], -1);
        chk("stray_m1", ack_seen[1], -1);
        rq = cyc + 1;
        issue(0, 1'b0, 7'h16, 8'h00);
        run(6);
        chk("stray_next_lat", ack_seen[0] - rq, 2);
        chk("stray_next_dat", m0_dat_o, 8'h40);

        // Random traffic from both masters
        rnd_mode = 1'b1;
        run(300);
        rnd_mode = 1'b0;
        run(12);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
